rs_encoder_param: RTL



---
 rtl/rs_encoder_param.sv | 132 +++++++++++++
 1 files changed

// File: rtl/rs_encoder_param.sv
// Systematic Reed-Solomon encoder over GF(2^SYM_W) with a valid/ready stream.
// Message symbols pass straight through, followed by N-K parity symbols taken
// from a division LFSR. The generator polynomial is built at elaboration time.
module rs_encoder_param #(
  parameter int          SYM_W     = 8,
  parameter int          N         = 255,
  parameter int          K         = 239,
  parameter int unsigned PRIM_POLY = 'h11D,
  parameter int          FCR       = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SYM_W-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SYM_W-1:0] out_data,
  output logic             out_sop,
  output logic             out_eop,
  output logic             out_is_par
);

  localparam int NPAR  = N - K;
  localparam int CNT_W = $clog2(N);

  typedef logic [SYM_W-1:0] sym_t;
  typedef enum logic {MSG, PAR} state_t;

  // Reduction polynomial without its x^SYM_W term
  localparam sym_t POLY_LO = sym_t'(PRIM_POLY);

  // GF multiply: shift-and-add with interleaved reduction
  function automatic sym_t gf_mul(sym_t a, sym_t b);
    sym_t p;
    sym_t x;
    p = '0;
    x = a;
    for (int i = 0; i < SYM_W; i++) begin
      if (b[i]) p = p ^ x;
      x = x[SYM_W-1] ? ((x << 1) ^ POLY_LO) : (x << 1);
    end
    return p;
  endfunction

  // g(x) = prod (x + alpha^(FCR+i)); returns the non-monic coefficients g[0..NPAR-1]
  function automatic logic [NPAR-1:0][SYM_W-1:0] gen_poly();
    logic [NPAR:0][SYM_W-1:0] g;
    sym_t root;
    g    = '0;
    g[0] = sym_t'(1);
    root = sym_t'(1);
    for (int j = 0; j < FCR; j++) root = gf_mul(root, sym_t'(2));
    for (int i = 0; i < NPAR; i++) begin
      for (int j = NPAR; j > 0; j--) g[j] = g[j-1] ^ gf_mul(g[j], root);
      g[0] = gf_mul(g[0], root);
      root = gf_mul(root, sym_t'(2));
    end
    return g[NPAR-1:0];
  endfunction

  localparam logic [NPAR-1:0][SYM_W-1:0] GEN = gen_poly();

  state_t                      state;
  logic [CNT_W-1:0]            cnt;
  logic [NPAR-1:0][SYM_W-1:0]  r;
  logic [NPAR-1:0][SYM_W-1:0]  r_msg;
  sym_t                        fb;
  logic                        slot_free;

  assign slot_free = !out_valid || out_ready;
  assign in_ready  = (state == MSG) && slot_free;

  // Next LFSR contents when a message symbol is absorbed
  always_comb begin
    fb       = in_data ^ r[NPAR-1];
    r_msg[0] = gf_mul(fb, GEN[0]);
    for (int i = 1; i < NPAR; i++) r_msg[i] = r[i-1] ^ gf_mul(fb, GEN[i]);
  end

  // Frame sequencer, parity LFSR and registered output stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= MSG;
      cnt        <= '0;
      r          <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_sop    <= 1'b0;
      out_eop    <= 1'b0;
      out_is_par <= 1'b0;
    end else begin
      if (out_ready) out_valid <= 1'b0;
      case (state)
        MSG: begin
          if (in_valid && slot_free) begin
            out_valid  <= 1'b1;
            out_data   <= in_data;
            out_is_par <= 1'b0;
            out_sop    <= (cnt == '0);
            out_eop    <= 1'b0;
            r          <= r_msg;
            if (cnt == CNT_W'(K - 1)) begin
              cnt   <= '0;
              state <= PAR;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        PAR: begin
          if (slot_free) begin
            out_valid  <= 1'b1;
            out_data   <= r[NPAR-1];
            out_is_par <= 1'b1;
            out_sop    <= 1'b0;
            out_eop    <= (cnt == CNT_W'(NPAR - 1));
            r          <= {r[NPAR-2:0], sym_t'(0)};
            if (cnt == CNT_W'(NPAR - 1)) begin
              cnt   <= '0;
              state <= MSG;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        default: state <= MSG;
      endcase
    end
  end

endmodule
